// File: rtl/iencode_pkg.sv
// Shared types and constants for the RV32I streaming instruction encoder.
// Holds the command class enum, the base opcodes, the error codes, the FSM
// state type and a small signed range helper used by the immediate checker.
package iencode_pkg;

  typedef enum logic [3:0] {
    CLS_LOAD   = 4'd0,
    CLS_STORE  = 4'd1,
    CLS_LUI    = 4'd2,
    CLS_AUIPC  = 4'd3,
    CLS_OP     = 4'd4,
    CLS_OPIMM  = 4'd5,
    CLS_BRANCH = 4'd6,
    CLS_JAL    = 4'd7,
    CLS_JALR   = 4'd8
  } cmd_class_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_RANGE  = 3'd1,
    ERR_ALIGN  = 3'd2,
    ERR_CLASS  = 3'd3,
    ERR_FUNCT3 = 3'd4,
    ERR_FULL   = 3'd5
  } err_code_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_FULL = 2'd3
  } state_e;

  function automatic logic imm_in(input logic signed [31:0] v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/iencode_if.sv
// Command and RAM-write bus of the instruction encoder.
//   cmd_*   : field-level command, valid/ready handshake (master -> encoder)
//   wr_*    : instruction RAM write port, wr_en/wr_ready handshake (encoder -> RAM)
// Modport slave is the encoder side; master is the command source / RAM side.
interface iencode_if #(parameter int ADDR_W = 10);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_class;
  logic [2:0]        cmd_funct3;
  logic              cmd_alt;
  logic [4:0]        cmd_rd;
  logic [4:0]        cmd_rs1;
  logic [4:0]        cmd_rs2;
  logic [31:0]       cmd_imm;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport slave (
    input  cmd_valid, cmd_class, cmd_funct3, cmd_alt, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    output cmd_ready,
    output wr_en, wr_addr, wr_data,
    input  wr_ready
  );

  modport master (
    output cmd_valid, cmd_class, cmd_funct3, cmd_alt, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    input  cmd_ready,
    input  wr_en, wr_addr, wr_data,
    output wr_ready
  );
endinterface

// File: rtl/iencode_pack.sv
// Combinational packer/checker: command fields -> 32-bit RV32I word.
// Ports: cls, funct3, alt, rd, rs1, rs2, imm in; word, err, code out.
// Macro IENC_RANGE_CHECK_EN enables immediate range/alignment checks
// (codes 1, 2); without it immediates are truncated to their field bits.
// Class and funct3 legality (codes 3, 4) are always checked.
module iencode_pack
  import iencode_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        err,
  output err_code_e   code
);

  logic       shift;
  logic       bad_f3;
  logic [6:0] funct7;
  err_code_e  imm_code;

`ifdef IENC_RANGE_CHECK_EN
  logic signed [31:0] simm;
  assign simm = imm;
`endif

  assign shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    word     = '0;
    bad_f3   = 1'b0;
    funct7   = '0;
    imm_code = ERR_NONE;
    case (cls)
      CLS_LOAD: begin
        word   = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
        bad_f3 = (funct3 == 3'd3) || (funct3 >= 3'd6);
`ifdef IENC_RANGE_CHECK_EN
        if (!imm_in(simm, -2048, 2047)) imm_code = ERR_RANGE;
`endif
      end
      CLS_STORE: begin
        word   = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
        bad_f3 = (funct3 > 3'd2);
`ifdef IENC_RANGE_CHECK_EN
        if (!imm_in(simm, -2048, 2047)) imm_code = ERR_RANGE;
`endif
      end
      CLS_LUI, CLS_AUIPC: begin
        word = {imm[31:12], rd, (cls == CLS_LUI) ? OPC_LUI : OPC_AUIPC};
`ifdef IENC_RANGE_CHECK_EN
        // U immediates must already be 4 KiB aligned
        if (imm[11:0] != 12'd0) imm_code = ERR_ALIGN;
`endif
      end
      CLS_OP: begin
        if (funct3 == 3'b000 || funct3 == 3'b101) funct7 = {1'b0, alt, 5'b0};
        word = {funct7, rs2, rs1, funct3, rd, OPC_OP};
      end
      CLS_OPIMM: begin
        if (shift) begin
          // only SRAI carries the alt bit; SLLI keeps funct7 zero
          if (funct3 == 3'b101) funct7 = {1'b0, alt, 5'b0};
          word = {funct7, imm[4:0], rs1, funct3, rd, OPC_OPIMM};
`ifdef IENC_RANGE_CHECK_EN
          if (!imm_in(simm, 0, 31)) imm_code = ERR_RANGE;
`endif
        end else begin
          word = {imm[11:0], rs1, funct3, rd, OPC_OPIMM};
`ifdef IENC_RANGE_CHECK_EN
          if (!imm_in(simm, -2048, 2047)) imm_code = ERR_RANGE;
`endif
        end
      end
      CLS_BRANCH: begin
        word   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
        bad_f3 = (funct3 == 3'd2) || (funct3 == 3'd3);
`ifdef IENC_RANGE_CHECK_EN
        if (!imm_in(simm, -4096, 4094)) imm_code = ERR_RANGE;
        else if (imm[0])                imm_code = ERR_ALIGN;
`endif
      end
      CLS_JAL: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
`ifdef IENC_RANGE_CHECK_EN
        if (!imm_in(simm, -1048576, 1048574)) imm_code = ERR_RANGE;
        else if (imm[0])                      imm_code = ERR_ALIGN;
`endif
      end
      CLS_JALR: begin
        word   = {imm[11:0], rs1, funct3, rd, OPC_JALR};
        bad_f3 = (funct3 != 3'd0);
`ifdef IENC_RANGE_CHECK_EN
        if (!imm_in(simm, -2048, 2047)) imm_code = ERR_RANGE;
`endif
      end
      default: ;
    endcase
  end

  // structural errors take priority over immediate errors
  always_comb begin
    if (cls > 4'd8)  code = ERR_CLASS;
    else if (bad_f3) code = ERR_FUNCT3;
    else             code = imm_code;
    err = (code != ERR_NONE);
  end

endmodule

// File: rtl/iencode.sv
// Streaming RV32I instruction encoder: accepts field-level commands, packs
// them and writes the words sequentially into instruction RAM.
// Ports: clk, rst (sync, active-high), start/base_addr (begin a program),
// bus (iencode_if.slave: cmd_* handshake and wr_* RAM port), count, busy,
// err, err_code.
// Macro IENC_RANGE_CHECK_EN (see iencode_pack) enables immediate checks.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting commands, writing words
// HALT  | a command was rejected; waits for start
// FULL  | last RAM word written; further commands flag err_code 5
module iencode
  import iencode_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  iencode_if.slave          bus,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              err,
  output logic [2:0]        err_code
);

  state_e            state, state_nx;
  logic              wr_en_q, wr_en_nx;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_nx;
  logic [31:0]       wr_data_q, wr_data_nx;
  logic [ADDR_W:0]   count_q, count_nx;
  logic              err_q, err_nx;
  err_code_e         code_q, code_nx;

  logic              cmd_ready_c;
  logic              cmd_fire;
  logic              wr_fire;
  logic              last_word;
  logic [31:0]       pk_word;
  logic              pk_err;
  err_code_e         pk_code;

  iencode_pack u_pack (
    .cls    (bus.cmd_class),
    .funct3 (bus.cmd_funct3),
    .alt    (bus.cmd_alt),
    .rd     (bus.cmd_rd),
    .rs1    (bus.cmd_rs1),
    .rs2    (bus.cmd_rs2),
    .imm    (bus.cmd_imm),
    .word   (pk_word),
    .err    (pk_err),
    .code   (pk_code)
  );

  assign wr_fire   = wr_en_q & bus.wr_ready;
  assign last_word = (wr_addr_q == ADDR_W'(DEPTH - 1)) || (count_q == (ADDR_W + 1)'(DEPTH - 1));

  always_comb begin
    state_nx    = state;
    wr_en_nx    = wr_en_q;
    wr_addr_nx  = wr_addr_q;
    wr_data_nx  = wr_data_q;
    count_nx    = count_q;
    err_nx      = err_q;
    code_nx     = code_q;
    cmd_ready_c = 1'b0;
    // a pending write to the last word leaves no room for another command,
    // and a command offered during start would be dropped by the reload
    if (state == S_RUN)
      cmd_ready_c = (~wr_en_q | bus.wr_ready) & ~(wr_en_q & last_word) & ~start;
    cmd_fire = bus.cmd_valid & cmd_ready_c;

    if (start) begin
      state_nx   = S_RUN;
      wr_en_nx   = 1'b0;
      wr_addr_nx = base_addr;
      count_nx   = '0;
      err_nx     = 1'b0;
      code_nx    = ERR_NONE;
    end else begin
      if (wr_fire) begin
        wr_en_nx = 1'b0;
        count_nx = count_q + 1'b1;
        // address holds on the final write so it never wraps
        if (last_word) state_nx = S_FULL;
        else           wr_addr_nx = wr_addr_q + 1'b1;
      end
      case (state)
        S_RUN: begin
          if (cmd_fire) begin
            if (pk_err) begin
              err_nx   = 1'b1;
              code_nx  = pk_code;
              state_nx = S_HALT;
            end else begin
              wr_en_nx   = 1'b1;
              wr_data_nx = pk_word;
            end
          end
        end
        S_FULL: begin
          if (bus.cmd_valid && !err_q) begin
            err_nx  = 1'b1;
            code_nx = ERR_FULL;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
    end else begin
      state     <= state_nx;
      wr_en_q   <= wr_en_nx;
      wr_addr_q <= wr_addr_nx;
      wr_data_q <= wr_data_nx;
      count_q   <= count_nx;
      err_q     <= err_nx;
      code_q    <= code_nx;
    end
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign count         = count_q;
  assign busy          = (state == S_RUN) || wr_en_q;
  assign err           = err_q;
  assign err_code      = code_q;

endmodule

// File: tb/tb_iencode.sv
module tb_iencode;
  localparam int AW = 10;
  localparam int DP = 1024;
`ifdef IENC_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count;
  logic          busy;
  logic          err;
  logic [2:0]    err_code;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  rdy_mode = 1;
  int  exp_addr = 0;
  int  n_exp = 0;
  wr_t q[$];

  iencode_if #(.ADDR_W(AW)) bus();

  iencode #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus),
    .count     (count),
    .busy      (busy),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] fld(input int v, input int w, input int lsb);
    logic [31:0] m;
    m = (32'h1 << w) - 32'h1;
    return (32'(v) & m) << lsb;
  endfunction

  function automatic bit f3_bad(input int cls, input int f3);
    case (cls)
      0:       return (f3 == 3) || (f3 == 6) || (f3 == 7);
      1:       return f3 > 2;
      6:       return (f3 == 2) || (f3 == 3);
      8:       return f3 != 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int model_err(input int cls, input int f3, input int imm);
    if (cls > 8) return 3;
    if (f3_bad(cls, f3)) return 4;
    if (RANGE_CHK) begin
      case (cls)
        0, 1, 8: if (imm < -2048 || imm > 2047) return 1;
        2, 3:    if ((imm & 32'hfff) != 0) return 2;
        5: begin
          if (f3 == 1 || f3 == 5) begin
            if (imm < 0 || imm > 31) return 1;
          end else if (imm < -2048 || imm > 2047) return 1;
        end
        6: begin
          if (imm < -4096 || imm > 4094) return 1;
          if ((imm & 1) != 0) return 2;
        end
        7: begin
          if (imm < -(2 ** 20) || imm > (2 ** 20) - 2) return 1;
          if ((imm & 1) != 0) return 2;
        end
        default: ;
      endcase
    end
    return 0;
  endfunction

  function automatic logic [31:0] model_word(input int cls, input int f3, input bit alt,
                                             input int rd, input int rs1, input int rs2, input int imm);
    logic [31:0] regs_i;
    int f7;
    regs_i = fld(rs1, 5, 15) | fld(f3, 3, 12) | fld(rd, 5, 7);
    case (cls)
      0: return fld(imm, 12, 20) | regs_i | 32'h03;
      1: return fld(imm >>> 5, 7, 25) | fld(rs2, 5, 20) | fld(rs1, 5, 15) | fld(f3, 3, 12)
                | fld(imm, 5, 7) | 32'h23;
      2: return (32'(imm) & 32'hfffff000) | fld(rd, 5, 7) | 32'h37;
      3: return (32'(imm) & 32'hfffff000) | fld(rd, 5, 7) | 32'h17;
      4: begin
        f7 = (alt && (f3 == 0 || f3 == 5)) ? 32 : 0;
        return fld(f7, 7, 25) | fld(rs2, 5, 20) | regs_i | 32'h33;
      end
      5: begin
        if (f3 == 1 || f3 == 5) begin
          f7 = (alt && f3 == 5) ? 32 : 0;
          return fld(f7, 7, 25) | fld(imm, 5, 20) | regs_i | 32'h13;
        end
        return fld(imm, 12, 20) | regs_i | 32'h13;
      end
      6: return fld(imm >>> 12, 1, 31) | fld(imm >>> 5, 6, 25) | fld(rs2, 5, 20) | fld(rs1, 5, 15)
                | fld(f3, 3, 12) | fld(imm >>> 1, 4, 8) | fld(imm >>> 11, 1, 7) | 32'h63;
      7: return fld(imm >>> 20, 1, 31) | fld(imm >>> 1, 10, 21) | fld(imm >>> 11, 1, 20)
                | fld(imm >>> 12, 8, 12) | fld(rd, 5, 7) | 32'h6f;
      8: return fld(imm, 12, 20) | regs_i | 32'h67;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int rand_imm(input int cls, input int f3);
    int v;
    case (cls)
      2, 3: v = ($urandom_range(0, 5) == 0) ? int'($urandom) : int'($urandom & 32'hfffff000);
      5: begin
        if (f3 == 1 || f3 == 5) v = int'($urandom_range(0, 35));
        else                    v = int'($urandom_range(0, 4400)) - 2200;
      end
      6: begin
        v = int'($urandom_range(0, 8200)) - 4100;
        if ($urandom_range(0, 5) != 0) v = v & ~1;
      end
      7: begin
        v = int'($urandom_range(0, 2 ** 21 + 8)) - (2 ** 20 + 4);
        if ($urandom_range(0, 5) != 0) v = v & ~1;
      end
      default: v = int'($urandom_range(0, 4400)) - 2200;
    endcase
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic [31:0] d);
    wr_t e;
    e.addr = AW'(exp_addr);
    e.data = d;
    q.push_back(e);
    exp_addr++;
    n_exp++;
  endtask

  task automatic start_run(input int base);
    base_addr = AW'(base);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = base;
    n_exp = 0;
  endtask

  task automatic send_cmd(input int cls, input int f3, input bit alt, input int rd, input int rs1,
                          input int rs2, input int imm, output int waited);
    bus.cmd_valid  = 1'b1;
    bus.cmd_class  = 4'(cls);
    bus.cmd_funct3 = 3'(f3);
    bus.cmd_alt    = alt;
    bus.cmd_rd     = 5'(rd);
    bus.cmd_rs1    = 5'(rs1);
    bus.cmd_rs2    = 5'(rs2);
    bus.cmd_imm    = 32'(imm);
    waited = 0;
    @(negedge clk);
    while (!bus.cmd_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.cmd_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cmd_accept_timeout: cmd_ready stayed 0 for %0d cycles, expected 1", waited);
      bus.cmd_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d writes outstanding, expected 0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  // ---------------- wr_ready driver ----------------
  initial begin
    bus.wr_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.wr_ready = 1'b0;
        1:       bus.wr_ready = 1'b1;
        default: bus.wr_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.wr_en === 1'b1 && bus.wr_ready === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", bus.wr_addr, bus.wr_data);
        end else begin
          e = q.pop_front();
          chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
          chk("wr_data", bus.wr_data, e.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int w;
    int cls, f3, rd, rs1, rs2, imm, code;
    bit alt;
    bus.cmd_valid = 1'b0; bus.cmd_class = '0; bus.cmd_funct3 = '0; bus.cmd_alt = 1'b0;
    bus.cmd_rd = '0; bus.cmd_rs1 = '0; bus.cmd_rs2 = '0; bus.cmd_imm = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", bus.wr_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single ADDI, 1-cycle latency
    rdy_mode = 1;
    start_run(16);
    push(32'h00500093);
    send_cmd(5, 0, 0, 1, 0, 0, 5, w);
    @(negedge clk);
    chk("t1_wr_en", 32'(bus.wr_en), 32'd1);
    chk("t1_wr_addr", 32'(bus.wr_addr), 32'h10);
    wait_drain();
    chk("t1_count", 32'(count), 32'd1);

    // SUB then BEQ back-to-back
    start_run(16);
    push(32'h402081B3);
    push(32'hFE208CE3);
    send_cmd(4, 0, 1, 3, 1, 2, 0, w);
    send_cmd(6, 0, 0, 0, 1, 2, -8, w);
    chk("t2_b2b_wait", 32'(w), 32'd0);
    wait_drain();
    chk("t2_count", 32'(count), 32'd2);

    // LUI held under backpressure
    rdy_mode = 0;
    start_run(48);
    push(32'h123452B7);
    send_cmd(2, 0, 0, 5, 0, 0, 32'h12345000, w);
    repeat (3) begin
      @(negedge clk);
      chk("t3_wr_en_held", 32'(bus.wr_en), 32'd1);
      chk("t3_wr_data_held", bus.wr_data, 32'h123452B7);
      chk("t3_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    rdy_mode = 1;
    wait_drain();
    chk("t3_count", 32'(count), 32'd1);

    // immediate boundary 2047 / 2048
    start_run(32);
    push(32'h7FF00093);
    send_cmd(5, 0, 0, 1, 0, 0, 2047, w);
`ifdef IENC_RANGE_CHECK_EN
    send_cmd(5, 0, 0, 1, 0, 0, 2048, w);
    @(negedge clk);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_err_code", 32'(err_code), 32'd1);
    chk("t4_halt_ready", 32'(bus.cmd_ready), 32'd0);
    chk("t4_halt_busy", 32'(busy), 32'd0);
    wait_drain();
    chk("t4_count", 32'(count), 32'd1);
`else
    push(32'h80000093);
    send_cmd(5, 0, 0, 1, 0, 0, 2048, w);
    wait_drain();
    chk("t4_err", 32'(err), 32'd0);
    chk("t4_count", 32'(count), 32'd2);
`endif

    // fill the last two words, third command flags full
    start_run(DP - 2);
    push(model_word(0, 2, 0, 4, 2, 0, 12));
    push(model_word(1, 2, 0, 0, 2, 4, -16));
    send_cmd(0, 2, 0, 4, 2, 0, 12, w);
    send_cmd(1, 2, 0, 0, 2, 4, -16, w);
    bus.cmd_valid = 1'b1;
    bus.cmd_class = 4'd4;
    repeat (3) @(negedge clk);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_err_code", 32'(err_code), 32'd5);
    chk("t5_count", 32'(count), 32'd2);
    chk("t5_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_addr_nowrap", 32'(bus.wr_addr), 32'(DP - 1));
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    start_run(0);
    @(negedge clk);
    chk("t5_restart_err", 32'(err), 32'd0);
    chk("t5_restart_code", 32'(err_code), 32'd0);
    chk("t5_restart_count", 32'(count), 32'd0);
    @(posedge clk); #1;

    // bad class and bad funct3
    start_run(64);
    send_cmd(9, 0, 0, 1, 1, 1, 0, w);
    @(negedge clk);
    chk("t6_class_err", 32'(err), 32'd1);
    chk("t6_class_code", 32'(err_code), 32'd3);
    chk("t6_class_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start_run(64);
    send_cmd(8, 1, 0, 1, 1, 0, 0, w);
    @(negedge clk);
    chk("t6_f3_code", 32'(err_code), 32'd4);
    @(posedge clk); #1;

    // reset during a stalled write
    start_run(64);
    push(model_word(0, 2, 0, 7, 3, 0, -4));
    send_cmd(0, 2, 0, 7, 3, 0, -4, w);
    wait_drain();
    rdy_mode = 0;
    @(posedge clk); #1;
    send_cmd(4, 0, 0, 1, 2, 3, 0, w);
    @(negedge clk);
    chk("t7_stalled", 32'(bus.wr_en), 32'd1);
    chk("t7_count_before", 32'(count), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t7_rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("t7_rst_count", 32'(count), 32'd0);
    chk("t7_rst_busy", 32'(busy), 32'd0);
    chk("t7_rst_addr", 32'(bus.wr_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // randomized commands against the model
    rdy_mode = 2;
    start_run(int'($urandom_range(0, 600)));
    for (int i = 0; i < 300; i++) begin
      cls = ($urandom_range(0, 24) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      f3 = int'($urandom_range(0, 7));
      while (f3_bad(cls, f3) && $urandom_range(0, 3) != 0) f3 = int'($urandom_range(0, 7));
      alt = 1'($urandom_range(0, 1));
      rd = int'($urandom_range(0, 31));
      rs1 = int'($urandom_range(0, 31));
      rs2 = int'($urandom_range(0, 31));
      imm = rand_imm(cls, f3);
      code = model_err(cls, f3, imm);
      if (code == 0) push(model_word(cls, f3, alt, rd, rs1, rs2, imm));
      send_cmd(cls, f3, alt, rd, rs1, rs2, imm, w);
      if (code != 0) begin
        @(negedge clk);
        chk("rand_err", 32'(err), 32'd1);
        chk("rand_err_code", 32'(err_code), 32'(code));
        wait_drain();
        start_run(int'($urandom_range(0, 600)));
      end
    end
    wait_drain();
    chk("rand_count", 32'(count), 32'(n_exp));
    chk("rand_no_err", 32'(err), 32'd0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
